// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding selects, load-use / branch / dmem-wait stall and flush.
// Define HAZARD_FWD_EN to build forwarding and the WB capture register; otherwise RAW hazards stall.
module hazard_ctrl #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [XLEN-1:0]   capt_data,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              bubble_wb,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   mw_s;
    logic   lu_s;

    // True when a producer with write enable targets the nonzero register rs.
    function automatic logic raw_hit(input logic [REG_AW-1:0] rs, input logic use_rs,
                                     input logic [REG_AW-1:0] rd, input logic we);
        return use_rs && we && (rd != {REG_AW{1'b0}}) && (rs == rd);
    endfunction

    assign mw_s  = dmem_req && !dmem_ready;
    assign state = state_r;

`ifdef HAZARD_FWD_EN
    logic              capt_valid_r;
    logic [REG_AW-1:0] capt_rd_r;
    logic [XLEN-1:0]   capt_data_r;

    // Select priority: youngest producer first, capture register last.
    function automatic logic [1:0] fwd_sel_f(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        if (raw_hit(rs, 1'b1, mem_rd, mem_reg_write)) begin
            sel = 2'b01;
        end else if (raw_hit(rs, 1'b1, wb_rd, wb_reg_write)) begin
            sel = 2'b10;
        end else if (raw_hit(rs, 1'b1, capt_rd_r, capt_valid_r)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign lu_s = ex_mem_read && (raw_hit(id_rs1, id_use_rs1, ex_rd, ex_reg_write) ||
                                  raw_hit(id_rs2, id_use_rs2, ex_rd, ex_reg_write));
    assign capt_data = capt_data_r;

    // Capture the retiring WB result when a memory stall begins; drop it once EX advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            capt_valid_r <= 1'b0;
            capt_rd_r    <= {REG_AW{1'b0}};
            capt_data_r  <= {XLEN{1'b0}};
        end else if (mw_s && (state_r != ST_MEM_WAIT) && raw_hit(wb_rd, 1'b1, wb_rd, wb_reg_write)) begin
            capt_valid_r <= 1'b1;
            capt_rd_r    <= wb_rd;
            capt_data_r  <= wb_data;
        end else if (!mw_s) begin
            capt_valid_r <= 1'b0;
        end else begin
            capt_valid_r <= capt_valid_r;
        end
    end

    // Operand selects, forced to the regfile path while in reset.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (rst_n) begin
            fwd_a_sel = fwd_sel_f(ex_rs1);
            fwd_b_sel = fwd_sel_f(ex_rs2);
        end else begin
            fwd_a_sel = 2'b00;
            fwd_b_sel = 2'b00;
        end
    end
`else
    logic unused_s;

    // Without write-through or bypass, any in-flight writer of an ID source is a hazard.
    assign lu_s = raw_hit(id_rs1, id_use_rs1, ex_rd, ex_reg_write)   ||
                  raw_hit(id_rs2, id_use_rs2, ex_rd, ex_reg_write)   ||
                  raw_hit(id_rs1, id_use_rs1, mem_rd, mem_reg_write) ||
                  raw_hit(id_rs2, id_use_rs2, mem_rd, mem_reg_write) ||
                  raw_hit(id_rs1, id_use_rs1, wb_rd, wb_reg_write)   ||
                  raw_hit(id_rs2, id_use_rs2, wb_rd, wb_reg_write);
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    assign capt_data = {XLEN{1'b0}};
    assign unused_s  = ^{ex_rs1, ex_rs2, ex_mem_read, wb_data};
`endif

    // Stall/flush decode: memory wait dominates, then taken branch, then load-use.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        bubble_wb = 1'b0;
        if (!rst_n) begin
            stall_if = 1'b0;
        end else if (mw_s) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
        end else if (ex_branch_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (lu_s) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end else begin
            stall_if = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (mw_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else if (lu_s && !ex_branch_taken) begin
                    state_nxt_s = ST_BUBBLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_BUBBLE: begin
                if (mw_s) begin
                    state_nxt_s = ST_MEM_WAIT;
`ifndef HAZARD_FWD_EN
                end else if (lu_s && !ex_branch_taken) begin
                    state_nxt_s = ST_BUBBLE;
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mw_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a rule-level reference model.
// Works in both builds (HAZARD_FWD_EN defined or not).
module tb_hazard_ctrl;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int M_RUN = 0, M_BUBBLE = 1, M_WAIT = 2;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic [XLEN-1:0] wb_data;
    logic ex_branch_taken, dmem_req, dmem_ready;
    logic [1:0] fwd_a_sel, fwd_b_sel, state;
    logic [XLEN-1:0] capt_data;
    logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb;

    hazard_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .capt_data(capt_data),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int              m_state = M_RUN;
    bit              m_cv = 1'b0;
    int              m_crd = 0;
    logic [XLEN-1:0] m_cdata = '0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit writes(int rs, bit use_rs, int rd, bit we);
        return use_rs && we && rd != 0 && rs == rd;
    endfunction

    function automatic bit m_mw();
        return dmem_req && !dmem_ready;
    endfunction

    function automatic bit m_lu();
        bit r;
        r = writes(id_rs1, id_use_rs1, ex_rd, ex_reg_write && (ex_mem_read || !FWD)) ||
            writes(id_rs2, id_use_rs2, ex_rd, ex_reg_write && (ex_mem_read || !FWD));
        if (!FWD)
            r = r || writes(id_rs1, id_use_rs1, mem_rd, mem_reg_write) ||
                     writes(id_rs2, id_use_rs2, mem_rd, mem_reg_write) ||
                     writes(id_rs1, id_use_rs1, wb_rd, wb_reg_write) ||
                     writes(id_rs2, id_use_rs2, wb_rd, wb_reg_write);
        return r;
    endfunction

    // Forwarding source: first matching producer in the list (mem, wb, capture) wins.
    function automatic int m_sel(int rs);
        int rds[3];
        bit wes[3];
        if (!FWD || !rst_n) return 0;
        rds = '{mem_rd, wb_rd, m_crd};
        wes = '{mem_reg_write, wb_reg_write, m_cv};
        for (int k = 0; k < 3; k++)
            if (writes(rs, 1'b1, rds[k], wes[k])) return k + 1;
        return 0;
    endfunction

    task automatic check_outputs();
        // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb}
        logic [6:0] ctl;
        ctl = 7'b0;
        if (rst_n) begin
            if (m_mw()) ctl = 7'b1111001;
            else if (ex_branch_taken) ctl = 7'b0000110;
            else if (m_lu()) ctl = 7'b1100010;
        end
        chk_eq("ctl", {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb}, ctl);
        chk_eq("state", state, m_state);
        chk_eq("fwd_a", fwd_a_sel, m_sel(ex_rs1));
        chk_eq("fwd_b", fwd_b_sel, m_sel(ex_rs2));
        chk_eq("capt_data", capt_data, m_cdata);
    endtask

    task automatic model_edge();
        bit mw, lu;
        mw = m_mw();
        lu = m_lu();
        if (!rst_n) begin
            m_state = M_RUN; m_cv = 1'b0; m_crd = 0; m_cdata = '0;
        end else begin
            if (FWD && mw && m_state != M_WAIT && wb_reg_write && wb_rd != 0) begin
                m_cv = 1'b1; m_crd = wb_rd; m_cdata = wb_data;
            end else if (!mw) begin
                m_cv = 1'b0;
            end
            if (mw) m_state = M_WAIT;
            else if (m_state == M_WAIT) m_state = M_RUN;
            else if (lu && !ex_branch_taken && (m_state == M_RUN || !FWD)) m_state = M_BUBBLE;
            else m_state = M_RUN;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1;
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write} = '0;
        wb_data = '0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic randomize_inputs();
        rst_n = ($urandom_range(0, 59) != 0);
        id_rs1 = REG_AW'($urandom_range(0, 7)); id_rs2 = REG_AW'($urandom_range(0, 7));
        ex_rs1 = REG_AW'($urandom_range(0, 7)); ex_rs2 = REG_AW'($urandom_range(0, 7));
        ex_rd  = REG_AW'($urandom_range(0, 7)); mem_rd = REG_AW'($urandom_range(0, 7));
        wb_rd  = REG_AW'($urandom_range(0, 7));
        id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
        ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
        mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
        wb_data = $urandom;
        ex_branch_taken = ($urandom_range(0, 5) == 0);
        dmem_req = ($urandom_range(0, 2) != 0);
        dmem_ready = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk); model_edge(); #1;
        step();                          // reset-state check with rst_n low
        idle();
        // EX/MEM and MEM/WB forward
        mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd6; wb_reg_write = 1'b1;
        ex_rs1 = 5'd5; ex_rs2 = 5'd6;
        step();
        // Load-use, then dependent instruction sees the load in WB
        idle(); ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        step();
        idle(); ex_rs2 = 5'd7; wb_rd = 5'd7; wb_reg_write = 1'b1;
        step();
        // Memory wait with capture
        idle(); wb_rd = 5'd3; wb_reg_write = 1'b1; wb_data = 32'hDEADBEEF; ex_rs1 = 5'd3; dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            wb_reg_write = 1'b0; wb_rd = 5'd0;
        end
        dmem_ready = 1'b1; step();
        dmem_req = 1'b0; step();
        // Branch during wait
        idle(); ex_branch_taken = 1'b1; dmem_req = 1'b1;
        step(); step();
        dmem_ready = 1'b1; step();
        // Branch plus load-use
        idle(); ex_branch_taken = 1'b1; ex_rd = 5'd4; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        id_rs1 = 5'd4; id_use_rs1 = 1'b1;
        step();
        // Reset mid-wait, then x0 sources
        idle(); wb_rd = 5'd9; wb_reg_write = 1'b1; wb_data = 32'h12345678; dmem_req = 1'b1;
        step(); step();
        rst_n = 1'b0; step();
        idle(); mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd0; wb_reg_write = 1'b1;
        ex_rd = 5'd0; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        step();
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
